tl_buffer_queued: RTL and testbench



---
 rtl/tl_pkg.sv | 47 ++++
 rtl/tl_buffer_queued_queue.sv | 96 +++++++++
 rtl/tl_buffer_queued.sv | 115 +++++++++++
 tb/tb_tl_buffer_queued.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-UL widths, opcodes and beat layouts for the queued buffer.
package tl_pkg;

  localparam int TL_ADDR_W = 32;
  localparam int TL_DATA_W = 64;
  localparam int TL_SIZE_W = 4;
  localparam int TL_SINK_W = 3;
  localparam int TL_MASK_W = TL_DATA_W / 8;

  localparam logic [2:0] A_PUT_FULL         = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL      = 3'd1;
  localparam logic [2:0] A_GET              = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA  = 3'd1;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_MASK_W-1:0] mask;
    logic [TL_DATA_W-1:0] data;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SINK_W-1:0] sink;
    logic                 denied;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } d_beat_t;

  // A zero-depth queue still gets a 1-bit count port (tied to 0).
  function automatic int cnt_w(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

  function automatic int a_beat_w(input int addr_w, input int data_w, input int size_w);
    return 3 + size_w + addr_w + data_w / 8 + data_w;
  endfunction

  function automatic int d_beat_w(input int data_w, input int size_w, input int sink_w);
    return 3 + 2 + size_w + sink_w + 1 + data_w + 1;
  endfunction

endpackage

// File: rtl/tl_buffer_queued_queue.sv
// Generic elastic queue with optional flow-through and pipe modes; depth 0 is a plain wire.
module tl_queue
  import tl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0,
  parameter int W     = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic [W-1:0]              enq_bits,
  output logic                      deq_valid,
  input  logic                      deq_ready,
  output logic [W-1:0]              deq_bits,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  if (DEPTH == 0) begin : g_wire
    assign enq_ready = deq_ready;
    assign deq_valid = enq_valid;
    assign deq_bits  = enq_bits;
    assign count     = '0;
  end else begin : g_store
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] enq_ptr;
    logic [PTR_W-1:0] deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;
    logic             bypass;
    logic             do_enq;
    logic             do_deq;

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;

    assign enq_ready = ~full | ((PIPE != 0) & deq_ready);
    assign deq_valid = ~empty | ((FLOW != 0) & enq_valid);

    // Empty without flow drives zeros so unwritten storage never leaks onto the payload.
    always_comb begin
      deq_bits = mem[deq_ptr];
      if (empty) deq_bits = (FLOW != 0) ? enq_bits : '0;
    end

    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_valid & deq_ready;

    // A flow-through beat is consumed downstream in the same cycle and never touches storage.
    assign bypass = (FLOW != 0) & empty & deq_ready;
    assign do_enq = enq_fire & ~bypass;
    assign do_deq = deq_fire & ~((FLOW != 0) & empty);

    always_ff @(posedge clock) begin
      if (reset) begin
        enq_ptr    <= '0;
        deq_ptr    <= '0;
        maybe_full <= 1'b0;
      end else begin
        if (do_enq) enq_ptr <= ptr_inc(enq_ptr);
        if (do_deq) deq_ptr <= ptr_inc(deq_ptr);
        if (do_enq != do_deq) maybe_full <= do_enq;
      end
    end

    always_ff @(posedge clock) begin
      if (do_enq) mem[enq_ptr] <= enq_bits;
    end

    always_comb begin
      count = '0;
      if (full) begin
        count = CNT_W'(DEPTH);
      end else if (enq_ptr >= deq_ptr) begin
        count = CNT_W'(enq_ptr - deq_ptr);
      end else begin
        count = CNT_W'(DEPTH - int'(deq_ptr) + int'(enq_ptr));
      end
    end
  end

endmodule

// File: rtl/tl_buffer_queued.sv
// TileLink-UL link buffer: one queue on the A (request) path and one on the D (response) path.
module tl_buffer_queued
  import tl_pkg::*;
#(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int A_FLOW  = 0,
  parameter int D_FLOW  = 0,
  parameter int A_PIPE  = 0,
  parameter int D_PIPE  = 0,
  parameter int ADDR_W  = TL_ADDR_W,
  parameter int DATA_W  = TL_DATA_W,
  parameter int SIZE_W  = TL_SIZE_W,
  parameter int SINK_W  = TL_SINK_W
) (
  input  logic                        clock,
  input  logic                        reset,

  output logic                        auto_in_a_ready,
  input  logic                        auto_in_a_valid,
  input  logic [2:0]                  auto_in_a_bits_opcode,
  input  logic [SIZE_W-1:0]           auto_in_a_bits_size,
  input  logic [ADDR_W-1:0]           auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0]         auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]           auto_in_a_bits_data,

  input  logic                        auto_in_d_ready,
  output logic                        auto_in_d_valid,
  output logic [2:0]                  auto_in_d_bits_opcode,
  output logic [1:0]                  auto_in_d_bits_param,
  output logic [SIZE_W-1:0]           auto_in_d_bits_size,
  output logic [SINK_W-1:0]           auto_in_d_bits_sink,
  output logic                        auto_in_d_bits_denied,
  output logic [DATA_W-1:0]           auto_in_d_bits_data,
  output logic                        auto_in_d_bits_corrupt,

  input  logic                        auto_out_a_ready,
  output logic                        auto_out_a_valid,
  output logic [2:0]                  auto_out_a_bits_opcode,
  output logic [SIZE_W-1:0]           auto_out_a_bits_size,
  output logic [ADDR_W-1:0]           auto_out_a_bits_address,
  output logic [DATA_W/8-1:0]         auto_out_a_bits_mask,
  output logic [DATA_W-1:0]           auto_out_a_bits_data,

  output logic                        auto_out_d_ready,
  input  logic                        auto_out_d_valid,
  input  logic [2:0]                  auto_out_d_bits_opcode,
  input  logic [1:0]                  auto_out_d_bits_param,
  input  logic [SIZE_W-1:0]           auto_out_d_bits_size,
  input  logic [SINK_W-1:0]           auto_out_d_bits_sink,
  input  logic                        auto_out_d_bits_denied,
  input  logic [DATA_W-1:0]           auto_out_d_bits_data,
  input  logic                        auto_out_d_bits_corrupt,

  output logic [cnt_w(A_DEPTH)-1:0]   a_count,
  output logic [cnt_w(D_DEPTH)-1:0]   d_count
);

  localparam int A_W = a_beat_w(ADDR_W, DATA_W, SIZE_W);
  localparam int D_W = d_beat_w(DATA_W, SIZE_W, SINK_W);

  logic [A_W-1:0] a_enq_bits;
  logic [A_W-1:0] a_deq_bits;
  logic [D_W-1:0] d_enq_bits;
  logic [D_W-1:0] d_deq_bits;

  // Field order matches a_beat_t / d_beat_t so the default build lines up with the package types.
  assign a_enq_bits = {auto_in_a_bits_opcode, auto_in_a_bits_size, auto_in_a_bits_address,
                       auto_in_a_bits_mask, auto_in_a_bits_data};
  assign {auto_out_a_bits_opcode, auto_out_a_bits_size, auto_out_a_bits_address,
          auto_out_a_bits_mask, auto_out_a_bits_data} = a_deq_bits;

  assign d_enq_bits = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                       auto_out_d_bits_sink, auto_out_d_bits_denied, auto_out_d_bits_data,
                       auto_out_d_bits_corrupt};
  assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
          auto_in_d_bits_sink, auto_in_d_bits_denied, auto_in_d_bits_data,
          auto_in_d_bits_corrupt} = d_deq_bits;

  tl_queue #(
    .DEPTH (A_DEPTH),
    .FLOW  (A_FLOW),
    .PIPE  (A_PIPE),
    .W     (A_W)
  ) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_in_a_valid),
    .enq_ready (auto_in_a_ready),
    .enq_bits  (a_enq_bits),
    .deq_valid (auto_out_a_valid),
    .deq_ready (auto_out_a_ready),
    .deq_bits  (a_deq_bits),
    .count     (a_count)
  );

  // Responses travel manager -> client, so the D queue enqueues from the out side.
  tl_queue #(
    .DEPTH (D_DEPTH),
    .FLOW  (D_FLOW),
    .PIPE  (D_PIPE),
    .W     (D_W)
  ) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_out_d_valid),
    .enq_ready (auto_out_d_ready),
    .enq_bits  (d_enq_bits),
    .deq_valid (auto_in_d_valid),
    .deq_ready (auto_in_d_ready),
    .deq_bits  (d_deq_bits),
    .count     (d_count)
  );

endmodule

// File: tb/tb_tl_buffer_queued.sv
// Bench for tl_buffer_queued: four configurations side by side, scoreboarded per channel.
module tb_tl_buffer_queued;
  import tl_pkg::*;

  localparam int N = 4;

  // Instance configurations: 0 pass-through, 1 default, 2 depth-1 pipe, 3 depth-3 flow.
  function automatic int f_a_dep(input int g);
    case (g)
      0: return 0;
      1: return 2;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int f_d_dep(input int g);
    return (g == 0) ? 0 : 2;
  endfunction

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic    [N-1:0]      in_a_valid;
  logic    [N-1:0]      in_a_ready;
  a_beat_t [N-1:0]      in_a;
  logic    [N-1:0]      out_a_valid;
  logic    [N-1:0]      out_a_ready;
  a_beat_t [N-1:0]      out_a;
  logic    [N-1:0]      out_d_valid;
  logic    [N-1:0]      out_d_ready;
  d_beat_t [N-1:0]      out_d;
  logic    [N-1:0]      in_d_valid;
  logic    [N-1:0]      in_d_ready;
  d_beat_t [N-1:0]      in_d;
  logic    [N-1:0][3:0] a_cnt;
  logic    [N-1:0][3:0] d_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic a_beat_t mk_a(input logic [2:0] op, input logic [31:0] addr,
                                   input logic [63:0] data);
    a_beat_t b;
    b.opcode  = op;
    b.size    = 4'd3;
    b.address = addr;
    b.mask    = 8'hff;
    b.data    = data;
    return b;
  endfunction

  function automatic d_beat_t mk_d(input logic [2:0] op, input logic [63:0] data);
    d_beat_t b;
    b.opcode  = op;
    b.param   = 2'd0;
    b.size    = 4'd3;
    b.sink    = 3'd1;
    b.denied  = 1'b0;
    b.data    = data;
    b.corrupt = 1'b0;
    return b;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int ACW = cnt_w(f_a_dep(g));
    localparam int DCW = cnt_w(f_d_dep(g));
    logic [ACW-1:0] ac;
    logic [DCW-1:0] dc;
    assign a_cnt[g] = 4'(ac);
    assign d_cnt[g] = 4'(dc);

    tl_buffer_queued #(
      .A_DEPTH (f_a_dep(g)),
      .D_DEPTH (f_d_dep(g)),
      .A_FLOW  ((g == 3) ? 1 : 0),
      .D_FLOW  (0),
      .A_PIPE  ((g == 2) ? 1 : 0),
      .D_PIPE  (0)
    ) u_dut (
      .clock                   (clock),
      .reset                   (reset),
      .auto_in_a_ready         (in_a_ready[g]),
      .auto_in_a_valid         (in_a_valid[g]),
      .auto_in_a_bits_opcode   (in_a[g].opcode),
      .auto_in_a_bits_size     (in_a[g].size),
      .auto_in_a_bits_address  (in_a[g].address),
      .auto_in_a_bits_mask     (in_a[g].mask),
      .auto_in_a_bits_data     (in_a[g].data),
      .auto_in_d_ready         (in_d_ready[g]),
      .auto_in_d_valid         (in_d_valid[g]),
      .auto_in_d_bits_opcode   (in_d[g].opcode),
      .auto_in_d_bits_param    (in_d[g].param),
      .auto_in_d_bits_size     (in_d[g].size),
      .auto_in_d_bits_sink     (in_d[g].sink),
      .auto_in_d_bits_denied   (in_d[g].denied),
      .auto_in_d_bits_data     (in_d[g].data),
      .auto_in_d_bits_corrupt  (in_d[g].corrupt),
      .auto_out_a_ready        (out_a_ready[g]),
      .auto_out_a_valid        (out_a_valid[g]),
      .auto_out_a_bits_opcode  (out_a[g].opcode),
      .auto_out_a_bits_size    (out_a[g].size),
      .auto_out_a_bits_address (out_a[g].address),
      .auto_out_a_bits_mask    (out_a[g].mask),
      .auto_out_a_bits_data    (out_a[g].data),
      .auto_out_d_ready        (out_d_ready[g]),
      .auto_out_d_valid        (out_d_valid[g]),
      .auto_out_d_bits_opcode  (out_d[g].opcode),
      .auto_out_d_bits_param   (out_d[g].param),
      .auto_out_d_bits_size    (out_d[g].size),
      .auto_out_d_bits_sink    (out_d[g].sink),
      .auto_out_d_bits_denied  (out_d[g].denied),
      .auto_out_d_bits_data    (out_d[g].data),
      .auto_out_d_bits_corrupt (out_d[g].corrupt),
      .a_count                 (ac),
      .d_count                 (dc)
    );

    a_beat_t sb_a[$];
    d_beat_t sb_d[$];
    int n_a = 0;
    int n_d = 0;

    // Push accepted beats, pop and compare delivered beats; a flow bypass pushes then pops.
    always @(negedge clock) begin
      if (reset) begin
        sb_a.delete();
        sb_d.delete();
      end else begin
        if (in_a_valid[g] && in_a_ready[g]) sb_a.push_back(in_a[g]);
        if (out_a_valid[g] && out_a_ready[g]) begin
          check("a_sb_pending", 128'(sb_a.size() != 0), 128'(1));
          if (sb_a.size() != 0) check("a_order", 128'(out_a[g]), 128'(sb_a.pop_front()));
          n_a++;
        end
        if (out_d_valid[g] && out_d_ready[g]) sb_d.push_back(out_d[g]);
        if (in_d_valid[g] && in_d_ready[g]) begin
          check("d_sb_pending", 128'(sb_d.size() != 0), 128'(1));
          if (sb_d.size() != 0) check("d_order", 128'(in_d[g]), 128'(sb_d.pop_front()));
          n_d++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    int cyc;
    logic fired;

    reset       = 1'b1;
    in_a_valid  = '0;
    in_a        = '0;
    out_a_ready = '1;
    out_d_valid = '0;
    out_d       = '0;
    in_d_ready  = '1;
    repeat (3) @(posedge clock);
    #1;

    for (int i = 0; i < N; i++) begin
      check("rst_out_a_valid", 128'(out_a_valid[i]), 128'(0));
      check("rst_in_d_valid", 128'(in_d_valid[i]), 128'(0));
      check("rst_a_cnt", 128'(a_cnt[i]), 128'(0));
      check("rst_d_cnt", 128'(d_cnt[i]), 128'(0));
    end
    reset = 1'b0;
    tick();

    // Pass-through: both channels combinational.
    in_a[0]        = mk_a(A_GET, 32'h8000_0000, 64'h0);
    in_a_valid[0]  = 1'b1;
    out_d[0]       = mk_d(D_ACCESS_ACK_DATA, 64'hDEAD_BEEF);
    out_d_valid[0] = 1'b1;
    #1;
    check("pt_a_valid", 128'(out_a_valid[0]), 128'(1));
    check("pt_a_bits", 128'(out_a[0]), 128'(mk_a(A_GET, 32'h8000_0000, 64'h0)));
    check("pt_a_ready", 128'(in_a_ready[0]), 128'(1));
    check("pt_d_valid", 128'(in_d_valid[0]), 128'(1));
    check("pt_d_data", 128'(in_d[0].data), 128'(64'hDEAD_BEEF));
    check("pt_d_opcode", 128'(in_d[0].opcode), 128'(D_ACCESS_ACK_DATA));
    tick();
    check("pt_a_cnt", 128'(a_cnt[0]), 128'(0));
    check("pt_d_cnt", 128'(d_cnt[0]), 128'(0));
    in_a_valid[0]  = 1'b0;
    out_d_valid[0] = 1'b0;
    tick();

    // Default depth 2 with downstream stalled.
    out_a_ready[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_a[1]       = mk_a(A_PUT_FULL, 32'h100 + 32'(i * 8), 64'hA0 + 64'(i));
      in_a_valid[1] = 1'b1;
      #1;
      check("fill_ready", 128'(in_a_ready[1]), 128'(1));
      tick();
    end
    in_a[1] = mk_a(A_PUT_FULL, 32'h110, 64'hA2);
    #1;
    check("full_ready", 128'(in_a_ready[1]), 128'(0));
    check("full_cnt", 128'(a_cnt[1]), 128'(2));
    check("full_head", 128'(out_a[1].address), 128'(32'h100));
    in_a_valid[1]  = 1'b0;
    out_a_ready[1] = 1'b1;
    tick();
    check("drain_cnt1", 128'(a_cnt[1]), 128'(1));
    check("drain_head2", 128'(out_a[1].address), 128'(32'h108));
    tick();
    check("drain_cnt0", 128'(a_cnt[1]), 128'(0));
    check("drain_valid0", 128'(out_a_valid[1]), 128'(0));

    // Streaming 100 random beats through the default queue.
    base = g_dut[1].n_a;
    for (int i = 0; i < 100; i++) begin
      in_a[1]       = mk_a(A_PUT_FULL, $urandom, {$urandom, $urandom});
      in_a_valid[1] = 1'b1;
      #1;
      check("st_ready", 128'(in_a_ready[1]), 128'(1));
      if (i > 0) check("st_out_valid", 128'(out_a_valid[1]), 128'(1));
      tick();
    end
    in_a_valid[1] = 1'b0;
    #1;
    check("st_last_valid", 128'(out_a_valid[1]), 128'(1));
    tick();
    check("st_delivered", 128'(g_dut[1].n_a - base), 128'(100));
    check("st_cnt0", 128'(a_cnt[1]), 128'(0));

    // Depth 1 with pipe: a full queue keeps accepting while draining.
    out_a_ready[2] = 1'b0;
    in_a[2]        = mk_a(A_PUT_FULL, 32'h200, 64'h200);
    in_a_valid[2]  = 1'b1;
    tick();
    check("pipe_full_cnt", 128'(a_cnt[2]), 128'(1));
    base = g_dut[2].n_a;
    out_a_ready[2] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_a[2] = mk_a(A_PUT_FULL, 32'h200 + 32'(i * 8), 64'h200 + 64'(i));
      #1;
      check("pipe_ready", 128'(in_a_ready[2]), 128'(1));
      check("pipe_valid", 128'(out_a_valid[2]), 128'(1));
      check("pipe_cnt", 128'(a_cnt[2]), 128'(1));
      tick();
    end
    in_a_valid[2] = 1'b0;
    tick();
    check("pipe_delivered", 128'(g_dut[2].n_a - base), 128'(11));
    check("pipe_cnt0", 128'(a_cnt[2]), 128'(0));

    // Depth 3 with flow: zero-latency bypass when empty, then random backpressure.
    base           = g_dut[3].n_a;
    out_a_ready[3] = 1'b1;
    in_a[3]        = mk_a(A_GET, 32'h300, 64'h0);
    in_a_valid[3]  = 1'b1;
    #1;
    check("flow_valid", 128'(out_a_valid[3]), 128'(1));
    check("flow_addr", 128'(out_a[3].address), 128'(32'h300));
    tick();
    check("flow_cnt", 128'(a_cnt[3]), 128'(0));
    k   = 0;
    cyc = 0;
    in_a[3] = mk_a(A_PUT_FULL, 32'h400, 64'h400);
    while (k < 50 && cyc < 2000) begin
      out_a_ready[3] = 1'($urandom_range(0, 1));
      #1;
      check("flow_cnt_max", 128'(a_cnt[3] <= 4'd3), 128'(1));
      fired = in_a_valid[3] & in_a_ready[3];
      tick();
      cyc++;
      if (fired) begin
        k++;
        in_a[3] = mk_a(A_PUT_FULL, 32'h400 + 32'(k * 8), 64'h400 + 64'(k));
      end
    end
    check("flow_sent", 128'(k), 128'(50));
    in_a_valid[3]  = 1'b0;
    out_a_ready[3] = 1'b1;
    cyc = 0;
    while (a_cnt[3] != 4'd0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("flow_drain_cnt", 128'(a_cnt[3]), 128'(0));
    check("flow_delivered", 128'(g_dut[3].n_a - base), 128'(51));

    // Reset with two D beats queued discards them.
    in_d_ready[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      out_d[1]       = mk_d(D_ACCESS_ACK_DATA, 64'h5000 + 64'(i));
      out_d_valid[1] = 1'b1;
      tick();
    end
    out_d_valid[1] = 1'b0;
    #1;
    check("d_pre_cnt", 128'(d_cnt[1]), 128'(2));
    check("d_pre_valid", 128'(in_d_valid[1]), 128'(1));
    reset = 1'b1;
    tick();
    check("d_rst_valid", 128'(in_d_valid[1]), 128'(0));
    check("d_rst_cnt", 128'(d_cnt[1]), 128'(0));
    reset         = 1'b0;
    in_d_ready[1] = 1'b1;
    tick();
    out_d[1]       = mk_d(D_ACCESS_ACK, 64'h1234);
    out_d_valid[1] = 1'b1;
    tick();
    out_d_valid[1] = 1'b0;
    #1;
    check("d_new_valid", 128'(in_d_valid[1]), 128'(1));
    check("d_new_data", 128'(in_d[1].data), 128'(64'h1234));
    check("d_new_cnt", 128'(d_cnt[1]), 128'(1));
    tick();
    check("d_after_valid", 128'(in_d_valid[1]), 128'(0));
    check("d_after_cnt", 128'(d_cnt[1]), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
